// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared state encoding, owner codes and
// framebuffer read-mode constants for fb_port_arbiter.
package fb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT_RD,
    ACK,
    DRAIN
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_C0   = 2'b01;
  localparam logic [1:0] OWN_C1   = 2'b10;

  localparam logic FB_MODE_HORIZ  = 1'b0;
  localparam logic FB_MODE_COLUMN = 1'b1;

  localparam int DEF_WIDTH      = 128;
  localparam int DEF_HEIGHT     = 64;
  localparam int DEF_RD_TIMEOUT = 255;

  function automatic logic in_range(
    input logic [7:0] x,
    input logic [7:0] y,
    input int         w,
    input int         h
  );
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/fb_rr_arbiter.sv
// fb_rr_arbiter: 2-way grant. req[1:0], last_grant in;
// gnt_vld/gnt_idx out. DISPLAY_PRIORITY_EN pins ties to client 0.
module fb_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_vld,
  output logic       gnt_idx
);

`ifdef DISPLAY_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    if (&req) begin
`ifdef DISPLAY_PRIORITY_EN
      gnt_idx = 1'b0;
`else
      gnt_idx = ~last_grant;
`endif
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one framebuffer port between the
// display reader (c0_*) and draw engine (c1_*); drives fb_*,
// returns cN_ack/cN_rdata/err_o. Option: DISPLAY_PRIORITY_EN.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = DEF_WIDTH,
  parameter int DISPLAY_HEIGHT = DEF_HEIGHT,
  parameter int RD_TIMEOUT     = DEF_RD_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c0_req,
  input  logic [7:0] c0_x,
  input  logic [7:0] c0_y,
  output logic       c0_ack,
  output logic [7:0] c0_rdata,
  input  logic       c1_req,
  input  logic       c1_we,
  input  logic       c1_mode,
  input  logic [7:0] c1_x,
  input  logic [7:0] c1_y,
  input  logic       c1_wdata,
  output logic       c1_ack,
  output logic [7:0] c1_rdata,
  output logic       err_o,
  output logic       fb_re,
  output logic       fb_we,
  output logic [7:0] fb_xpos,
  output logic [7:0] fb_ypos,
  output logic       fb_mode,
  output logic       fb_wdata,
  input  logic [7:0] fb_dout,
  input  logic       fb_data_valid,
  output logic [1:0] owner_o
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic       gnt_vld, gnt_idx;

  logic       re_d, we_d, mode_d, wdata_d;
  logic [7:0] x_d, y_d;
  logic [1:0] owner_d;
  logic       c0_ack_d, c1_ack_d, err_d;
  logic [7:0] c0_rdata_d, c1_rdata_d;

  logic       do_ack, ack_c1, ack_err;
  logic [7:0] ack_data;

  fb_rr_arbiter u_rr (
    .req        ({c1_req, c0_req}),
    .last_grant (last_q),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    re_d     = fb_re;
    we_d     = 1'b0;
    x_d      = fb_xpos;
    y_d      = fb_ypos;
    mode_d   = fb_mode;
    wdata_d  = fb_wdata;
    owner_d  = owner_o;
    do_ack   = 1'b0;
    ack_c1   = (owner_o == OWN_C1);
    ack_err  = 1'b0;
    ack_data = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          last_d  = gnt_idx;
          owner_d = gnt_idx ? OWN_C1 : OWN_C0;
          x_d     = gnt_idx ? c1_x : c0_x;
          y_d     = gnt_idx ? c1_y : c0_y;
          mode_d  = gnt_idx ? c1_mode : FB_MODE_COLUMN;
          wdata_d = gnt_idx & c1_wdata;
          cnt_d   = '0;
          ack_c1  = gnt_idx;
          if (!in_range(x_d, y_d, DISPLAY_WIDTH,
                        DISPLAY_HEIGHT)) begin
            state_d = ACK;
            do_ack  = 1'b1;
            ack_err = 1'b1;
          end else if (gnt_idx && c1_we) begin
            state_d = WRITE;
            we_d    = 1'b1;
          end else begin
            state_d = WAIT_RD;
            re_d    = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = ACK;
        do_ack  = 1'b1;
      end
      WAIT_RD: begin
        if (fb_data_valid) begin
          state_d  = ACK;
          re_d     = 1'b0;
          do_ack   = 1'b1;
          ack_data = fb_dout;
        end else if (cnt_q == 8'(RD_TIMEOUT - 1)) begin
          // Counter would reach RD_TIMEOUT: abort the read.
          state_d = ACK;
          re_d    = 1'b0;
          do_ack  = 1'b1;
          ack_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!fb_data_valid) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        re_d    = 1'b0;
        owner_d = OWN_NONE;
      end
    endcase
    c0_ack_d   = do_ack & ~ack_c1;
    c1_ack_d   = do_ack & ack_c1;
    c0_rdata_d = c0_ack_d ? ack_data : '0;
    c1_rdata_d = c1_ack_d ? ack_data : '0;
    err_d      = do_ack & ack_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      c0_ack   <= 1'b0;
      c0_rdata <= '0;
      c1_ack   <= 1'b0;
      c1_rdata <= '0;
      err_o    <= 1'b0;
      fb_re    <= 1'b0;
      fb_we    <= 1'b0;
      fb_xpos  <= '0;
      fb_ypos  <= '0;
      fb_mode  <= 1'b0;
      fb_wdata <= 1'b0;
      owner_o  <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      c0_ack   <= c0_ack_d;
      c0_rdata <= c0_rdata_d;
      c1_ack   <= c1_ack_d;
      c1_rdata <= c1_rdata_d;
      err_o    <= err_d;
      fb_re    <= re_d;
      fb_we    <= we_d;
      fb_xpos  <= x_d;
      fb_ypos  <= y_d;
      fb_mode  <= mode_d;
      fb_wdata <= wdata_d;
      owner_o  <= owner_d;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed bench for fb_port_arbiter with
// a small framebuffer model returning data after a set latency.
module tb_fb_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       c0_req;
  logic [7:0] c0_x, c0_y;
  logic       c0_ack;
  logic [7:0] c0_rdata;
  logic       c1_req, c1_we, c1_mode, c1_wdata;
  logic [7:0] c1_x, c1_y;
  logic       c1_ack;
  logic [7:0] c1_rdata;
  logic       err_o;
  logic       fb_re, fb_we, fb_mode, fb_wdata;
  logic [7:0] fb_xpos, fb_ypos;
  logic [7:0] fb_dout = 8'h00;
  logic       fb_data_valid = 1'b0;
  logic [1:0] owner_o;

  int checks = 0;
  int failures = 0;

  int         lat = 1;
  logic [7:0] mdata = 8'h00;
  int         re_cnt = 0;

  int         re_cycles, we_cycles, both_hi;
  logic [7:0] we_x, we_y;
  logic       we_wd, re_mode;

  fb_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .c0_req        (c0_req),
    .c0_x          (c0_x),
    .c0_y          (c0_y),
    .c0_ack        (c0_ack),
    .c0_rdata      (c0_rdata),
    .c1_req        (c1_req),
    .c1_we         (c1_we),
    .c1_mode       (c1_mode),
    .c1_x          (c1_x),
    .c1_y          (c1_y),
    .c1_wdata      (c1_wdata),
    .c1_ack        (c1_ack),
    .c1_rdata      (c1_rdata),
    .err_o         (err_o),
    .fb_re         (fb_re),
    .fb_we         (fb_we),
    .fb_xpos       (fb_xpos),
    .fb_ypos       (fb_ypos),
    .fb_mode       (fb_mode),
    .fb_wdata      (fb_wdata),
    .fb_dout       (fb_dout),
    .fb_data_valid (fb_data_valid),
    .owner_o       (owner_o)
  );

  always #5 clk = ~clk;

  // Framebuffer: valid rises lat cycles after fb_re, holds
  // until fb_re drops. lat=0 never answers.
  always @(posedge clk) begin
    if (fb_re) begin
      if (lat > 0 && re_cnt == lat - 1) begin
        fb_data_valid <= 1'b1;
        fb_dout       <= mdata;
      end
      re_cnt <= re_cnt + 1;
    end else begin
      re_cnt        <= 0;
      fb_data_valid <= 1'b0;
      fb_dout       <= 8'h00;
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_ack(input int limit, output int n,
                          output int who);
    n = 0;
    who = -1;
    re_cycles = 0;
    we_cycles = 0;
    both_hi = 0;
    while (who < 0 && n < limit) begin
      @(negedge clk);
      n++;
      if (fb_re) begin
        re_cycles++;
        re_mode = fb_mode;
      end
      if (fb_we) begin
        we_cycles++;
        we_x  = fb_xpos;
        we_y  = fb_ypos;
        we_wd = fb_wdata;
      end
      if (fb_re && fb_we) both_hi++;
      if (c0_ack && c1_ack) who = 2;
      else if (c0_ack) who = 0;
      else if (c1_ack) who = 1;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({c0_ack, c0_rdata, c1_ack, c1_rdata, err_o} !== 19'd0) begin
      failures++;
      $display("FAIL reset_client_outs got %h want 0",
               {c0_ack, c0_rdata, c1_ack, c1_rdata, err_o});
    end
    checks++;
    if ({fb_re, fb_we, fb_xpos, fb_ypos, fb_mode, fb_wdata,
         owner_o} !== 22'd0) begin
      failures++;
      $display("FAIL reset_fb_outs got %h want 0",
               {fb_re, fb_we, fb_xpos, fb_ypos, fb_mode,
                fb_wdata, owner_o});
    end
  endtask

  task automatic test_c0_read;
    int n, who;
    lat = 2;
    mdata = 8'hA5;
    c0_x = 8'd5;
    c0_y = 8'd16;
    c0_req = 1'b1;
    wait_ack(20, n, who);
    checks++;
    if (who !== 0 || n !== 4) begin
      failures++;
      $display("FAIL c0_read_ack got who=%0d n=%0d want 0/4",
               who, n);
    end
    checks++;
    if (c0_rdata !== 8'hA5 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL c0_read_data got %h err=%b want a5 err=0",
               c0_rdata, err_o);
    end
    checks++;
    if (re_mode !== 1'b1 || re_cycles !== 3 || we_cycles !== 0) begin
      failures++;
      $display("FAIL c0_read_fb got mode=%b re=%0d we=%0d want 1/3/0",
               re_mode, re_cycles, we_cycles);
    end
    checks++;
    if (fb_xpos !== 8'd5 || fb_ypos !== 8'd16 || c1_rdata !== 8'd0) begin
      failures++;
      $display("FAIL c0_read_pos got x=%0d y=%0d c1d=%h want 5/16/0",
               fb_xpos, fb_ypos, c1_rdata);
    end
    c0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (c0_ack !== 1'b0 || c0_rdata !== 8'd0) begin
      failures++;
      $display("FAIL c0_ack_pulse got ack=%b d=%h want 0/0",
               c0_ack, c0_rdata);
    end
    idle(4);
  endtask

  task automatic test_write;
    int n, who;
    c1_we = 1'b1;
    c1_mode = 1'b0;
    c1_x = 8'd127;
    c1_y = 8'd63;
    c1_wdata = 1'b1;
    c1_req = 1'b1;
    wait_ack(20, n, who);
    c1_req = 1'b0;
    checks++;
    if (who !== 1 || n !== 2) begin
      failures++;
      $display("FAIL write_ack got who=%0d n=%0d want 1/2", who, n);
    end
    checks++;
    if (we_cycles !== 1 || re_cycles !== 0) begin
      failures++;
      $display("FAIL write_strobe got we=%0d re=%0d want 1/0",
               we_cycles, re_cycles);
    end
    checks++;
    if (we_x !== 8'd127 || we_y !== 8'd63 || we_wd !== 1'b1) begin
      failures++;
      $display("FAIL write_fields got x=%0d y=%0d d=%b want 127/63/1",
               we_x, we_y, we_wd);
    end
    checks++;
    if (err_o !== 1'b0 || c1_rdata !== 8'd0) begin
      failures++;
      $display("FAIL write_resp got err=%b d=%h want 0/0",
               err_o, c1_rdata);
    end
    idle(4);
  endtask

  task automatic test_out_of_range;
    int n, who;
    lat = 1;
    mdata = 8'hFF;
    c1_we = 1'b0;
    c1_x = 8'd128;
    c1_y = 8'd0;
    c1_req = 1'b1;
    wait_ack(20, n, who);
    c1_req = 1'b0;
    checks++;
    if (who !== 1 || n !== 1) begin
      failures++;
      $display("FAIL oor_ack got who=%0d n=%0d want 1/1", who, n);
    end
    checks++;
    if (err_o !== 1'b1 || c1_rdata !== 8'd0 || re_cycles !== 0) begin
      failures++;
      $display("FAIL oor_resp got err=%b d=%h re=%0d want 1/0/0",
               err_o, c1_rdata, re_cycles);
    end
    idle(4);
  endtask

  task automatic test_timeout;
    int n, who;
    lat = 0;
    c1_we = 1'b0;
    c1_mode = 1'b0;
    c1_x = 8'd3;
    c1_y = 8'd4;
    c1_req = 1'b1;
    wait_ack(400, n, who);
    c1_req = 1'b0;
    checks++;
    if (who !== 1 || n !== 256 || re_cycles !== 255) begin
      failures++;
      $display("FAIL timeout_len got who=%0d n=%0d re=%0d want 1/256/255",
               who, n, re_cycles);
    end
    checks++;
    if (err_o !== 1'b1 || c1_rdata !== 8'd0) begin
      failures++;
      $display("FAIL timeout_resp got err=%b d=%h want 1/0",
               err_o, c1_rdata);
    end
    idle(4);
    lat = 1;
    mdata = 8'h3C;
    c1_req = 1'b1;
    wait_ack(20, n, who);
    c1_req = 1'b0;
    checks++;
    if (who !== 1 || n !== 3) begin
      failures++;
      $display("FAIL after_timeout_ack got who=%0d n=%0d want 1/3",
               who, n);
    end
    checks++;
    if (c1_rdata !== 8'h3C || err_o !== 1'b0 || re_mode !== 1'b0) begin
      failures++;
      $display("FAIL after_timeout_data got d=%h err=%b m=%b want 3c/0/0",
               c1_rdata, err_o, re_mode);
    end
    idle(4);
  endtask

  task automatic test_back_to_back;
    int n, who, exp;
    logic [1:0] exp_own;
    lat = 1;
    mdata = 8'h5A;
    c0_x = 8'd10;
    c0_y = 8'd8;
    c1_we = 1'b1;
    c1_x = 8'd20;
    c1_y = 8'd30;
    c1_wdata = 1'b0;
    c0_req = 1'b1;
    c1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_ack(20, n, who);
`ifdef DISPLAY_PRIORITY_EN
      exp = 0;
`else
      exp = i % 2;
`endif
      exp_own = (exp == 0) ? 2'b01 : 2'b10;
      checks++;
      if (who !== exp || owner_o !== exp_own || both_hi !== 0) begin
        failures++;
        $display("FAIL rr_grant%0d got who=%0d own=%b both=%0d want %0d/%b/0",
                 i, who, owner_o, both_hi, exp, exp_own);
      end
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    idle(5);
  endtask

  task automatic test_reset_mid;
    int n, who;
    lat = 0;
    c0_x = 8'd1;
    c0_y = 8'd8;
    c0_req = 1'b1;
    idle(3);
    checks++;
    if (fb_re !== 1'b1 || owner_o !== 2'b01) begin
      failures++;
      $display("FAIL mid_pre got re=%b own=%b want 1/01", fb_re, owner_o);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fb_re !== 1'b0 || fb_we !== 1'b0 || owner_o !== 2'b00 ||
        c0_ack !== 1'b0 || c1_ack !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got re=%b we=%b own=%b a0=%b a1=%b want 0",
               fb_re, fb_we, owner_o, c0_ack, c1_ack);
    end
    lat = 1;
    mdata = 8'h77;
    c1_we = 1'b1;
    c1_req = 1'b1;
    reset = 1'b0;
    wait_ack(20, n, who);
    c0_req = 1'b0;
    c1_req = 1'b0;
    checks++;
    if (who !== 0 || n !== 3 || c0_rdata !== 8'h77) begin
      failures++;
      $display("FAIL post_reset_grant got who=%0d n=%0d d=%h want 0/3/77",
               who, n, c0_rdata);
    end
    idle(5);
  endtask

  initial begin
    reset = 1'b1;
    c0_req = 1'b0;
    c0_x = 8'd0;
    c0_y = 8'd0;
    c1_req = 1'b0;
    c1_we = 1'b0;
    c1_mode = 1'b0;
    c1_x = 8'd0;
    c1_y = 8'd0;
    c1_wdata = 1'b0;
    idle(3);
    test_reset();
    reset = 1'b0;
    idle(2);
    test_c0_read();
    test_write();
    test_out_of_range();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
